// File: rtl/hex_keypad_entry_pkg.sv
// Shared types and constants for the hex keypad entry block.
// Holds the state encoding, default timing parameters and the key map.
package hex_keypad_entry_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam int SCAN_DIV_DEF     = 100000;
  localparam int DEBOUNCE_CNT_DEF = 2000000;

  // Indexed by {row, col}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // True when exactly one active-low column is asserted.
  function automatic logic one_cold(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

endpackage

// File: rtl/hex_keypad_entry_decode.sv
// Combinational key decoder: row index plus one-hot column to hex value.
// A column pattern that is not one-hot decodes as column 0.
module keypad_decode
  import hex_keypad_entry_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [3:0] col_onehot_i,
  output logic [3:0] key_o
);

  logic [1:0] col_idx;

  always_comb begin
    col_idx = 2'd0;
    case (col_onehot_i)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    key_o = KEY_MAP[{row_idx_i, col_idx}];
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 active-low keypad, debounces presses and releases, and shifts
// accepted hex digits into an 8-digit entry register.
//
// state       | meaning
// ST_SCAN     | rotate rows, sample columns in last cycle of each row slot
// ST_DEBOUNCE | row held, captured column pattern must stay stable
// ST_PRESSED  | single cycle: key accepted, key_valid pulses
// ST_RELEASE  | row held until all columns stay high long enough
module hex_keypad_entry
  import hex_keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  input  logic        clear,
  output logic [3:0]  row_out,
  output logic [31:0] data_out,
  output logic [3:0]  digit_count,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LOAD = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]        col_meta_q, col_s_q;
  state_e            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        cap_col_q, cap_col_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [3:0]        key_dec;
  logic              accept;

  keypad_decode u_decode (
    .row_idx_i    (row_q),
    .col_onehot_i (~cap_col_q),
    .key_o        (key_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      state_q    <= ST_SCAN;
      row_q      <= 2'd0;
      scan_cnt_q <= SCAN_LOAD;
      deb_cnt_q  <= DEB_LOAD;
      cap_col_q  <= 4'hF;
      data_q     <= '0;
      count_q    <= '0;
      key_code_q <= '0;
    end else begin
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
      state_q    <= state_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      cap_col_q  <= cap_col_d;
      data_q     <= data_d;
      count_q    <= count_d;
      key_code_q <= key_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    cap_col_d  = cap_col_q;
    data_d     = data_q;
    count_d    = count_q;
    key_code_d = key_code_q;
    accept     = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == '0) begin
          if (one_cold(col_s_q)) begin
            cap_col_d = col_s_q;
            deb_cnt_d = DEB_LOAD;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_d      = row_q + 2'd1;
            scan_cnt_d = SCAN_LOAD;
          end
        end else begin
          scan_cnt_d = scan_cnt_q - 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (col_s_q != cap_col_q) begin
          state_d    = ST_SCAN;
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_LOAD;
        end else if (deb_cnt_q == '0) begin
          state_d = ST_PRESSED;
          accept  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q - 1'b1;
        end
      end
      ST_PRESSED: begin
        state_d   = ST_RELEASE;
        deb_cnt_d = DEB_LOAD;
      end
      ST_RELEASE: begin
        if (col_s_q != 4'hF) begin
          deb_cnt_d = DEB_LOAD;
        end else if (deb_cnt_q == '0) begin
          state_d    = ST_SCAN;
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_LOAD;
        end else begin
          deb_cnt_d = deb_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    // Registering on entry makes the new digit visible during the PRESSED cycle.
    if (accept) begin
      key_code_d = key_dec;
      data_d     = {data_q[27:0], key_dec};
      count_d    = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
    end
    if (clear) begin
      data_d  = '0;
      count_d = '0;
    end
  end

  assign row_out     = ~(4'b0001 << row_q);
  assign data_out    = data_q;
  assign digit_count = count_q;
  assign key_valid   = (state_q == ST_PRESSED);
  assign key_code    = key_code_q;

endmodule

// File: doc/hex_keypad_entry.md
HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per row slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 2000000, consecutive stable cycles for press/release acceptance (20 ms).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous.
REQ-006 SHALL have port clear  input  1  synchronous pulse; empties the entry register.
REQ-007 SHALL have port row_out  output  4  keypad rows, active-low, exactly one bit low at all times.
REQ-008 SHALL have port data_out  output  32  entered value, 8 hex nibbles, newest digit in [3:0].
REQ-009 SHALL have port digit_count  output  4  number of digits entered, 0..8.
REQ-010 SHALL have port key_valid  output  1  one-cycle pulse per accepted key.
REQ-011 SHALL have port key_code  output  4  hex value of last accepted key; held between pulses.

Function
REQ-012 SHALL pass col_in through a 2-flop synchronizer; all decisions use synchronized columns (col_s).
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 SCAN: row index advances 0->1->2->3->0 every SCAN_DIV cycles; row r drives row_out bit r low.
REQ-015 SCAN: col_s sampled only in last cycle of a row slot; exactly one column low -> capture row/col, go DEBOUNCE, row held; zero or >1 columns low -> advance row.
REQ-016 DEBOUNCE: col_s equal to captured pattern for DEBOUNCE_CNT consecutive cycles -> PRESSED; any mismatch -> SCAN, resuming at next row.
REQ-017 PRESSED: lasts exactly one cycle; key_valid=1, key_code=decoded key, data_out/digit_count updated same cycle; next state RELEASE.
REQ-018 RELEASE: row held; col_s==4'hF for DEBOUNCE_CNT consecutive cycles -> SCAN at next row; any low column restarts the count.
REQ-019 Key map (row: col0..col3): row0 1 2 3 A; row1 4 5 6 B; row2 7 8 9 C; row3 0 F E D.
REQ-020 Accepted key: data_out <= {data_out[27:0], key_code}; digit_count increments, saturating at 8; MSB nibble discarded beyond 8 digits.
REQ-021 clear (not in reset): data_out<=0, digit_count<=0 next cycle; FSM and key_code unaffected.
REQ-022 clear coincident with PRESSED: clear wins; data_out=0, digit_count=0, key_valid still pulses with key_code updated.
REQ-023 Key held indefinitely SHALL produce exactly one key_valid pulse.
REQ-024 Press-to-key_valid latency SHALL be 2 (sync) + up to 4*SCAN_DIV + DEBOUNCE_CNT + 1 cycles.

Reset
REQ-025 On rst: state SCAN, row index 0, row_out=4'b1110, data_out=0, digit_count=0, key_valid=0, key_code=0, all counters and synchronizer flops cleared to idle (synchronizer to 4'hF).
REQ-026 rst asserted mid-DEBOUNCE/RELEASE SHALL abort without emitting key_valid.

Structure
REQ-027 Shared package SHALL hold FSM state encoding, default SCAN_DIV/DEBOUNCE_CNT, and the 16-entry key map constants.
REQ-028 One combinational sub-module keypad_decode (row index, column one-hot -> 4-bit hex) SHALL be instantiated.
REQ-029 Counters SHALL be sized from parameters; no other sub-modules.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-030 Reset then idle columns -> row_out cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts.
REQ-031 Hold row1/col2 (key 6) 40 cycles then release -> single key_valid, key_code=6, data_out=0x00000006, digit_count=1.
REQ-032 Press 1,2,...,9 in sequence -> data_out=0x23456789, digit_count=8.
REQ-033 Bounce col low 3 cycles/high 2 repeatedly -> no key_valid; then stable -> one pulse.
REQ-034 Two columns of row0 low together -> no key_valid, scanning continues.
REQ-035 clear in the PRESSED cycle of key A -> key_valid=1, key_code=A, data_out=0, digit_count=0.
